// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - op codes, RAM control constants and op classification helpers
// Shared by mem_access_ctrl and mem_lane_align. Op bus is MEM_OP_W bits wide;
// codes 9..15 are undefined and treated like MEM_OP_NONE.
package mem_access_ctrl_pkg;

  localparam int MEM_OP_W = 4;

  localparam logic        CHIP_ENABLE   = 1'b1;
  localparam logic        CHIP_DISABLE  = 1'b0;
  localparam logic        WRITE_ENABLE  = 1'b1;
  localparam logic        WRITE_DISABLE = 1'b0;
  localparam logic [31:0] ZERO_WORD     = 32'h0000_0000;

  localparam logic [MEM_OP_W-1:0] MEM_OP_NONE = 4'd0;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LB   = 4'd1;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LBU  = 4'd2;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LH   = 4'd3;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LHU  = 4'd4;
  localparam logic [MEM_OP_W-1:0] MEM_OP_LW   = 4'd5;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SB   = 4'd6;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SH   = 4'd7;
  localparam logic [MEM_OP_W-1:0] MEM_OP_SW   = 4'd8;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } mem_state_e;

  function automatic logic op_is_load(input logic [MEM_OP_W-1:0] op);
    return (op >= MEM_OP_LB) && (op <= MEM_OP_LW);
  endfunction

  function automatic logic op_is_store(input logic [MEM_OP_W-1:0] op);
    return (op >= MEM_OP_SB) && (op <= MEM_OP_SW);
  endfunction

  function automatic logic op_is_byte(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_LB) || (op == MEM_OP_LBU) || (op == MEM_OP_SB);
  endfunction

  function automatic logic op_is_half(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_LH) || (op == MEM_OP_LHU) || (op == MEM_OP_SH);
  endfunction

  function automatic logic op_is_word(input logic [MEM_OP_W-1:0] op);
    return (op == MEM_OP_LW) || (op == MEM_OP_SW);
  endfunction

  // Only meaningful when alignment exceptions are enabled.
  function automatic logic op_misaligned(input logic [MEM_OP_W-1:0] op,
                                         input logic [1:0]          addr_lo);
    return (op_is_half(op) && addr_lo[0]) || (op_is_word(op) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - big-endian byte-lane select, store replication and load extension
// Ports: op/addr_lo select the lane(s); wdata is right-justified store data;
// rdata is the raw RAM word. sel (bit3 = [31:24]), lane_wdata (replicated
// store data) and ext_rdata (sign/zero-extended load result) are combinational.
module mem_lane_align
  import mem_access_ctrl_pkg::*;
(
  input  logic [MEM_OP_W-1:0] op,
  input  logic [1:0]          addr_lo,
  input  logic [31:0]         wdata,
  input  logic [31:0]         rdata,
  output logic [3:0]          sel,
  output logic [31:0]         lane_wdata,
  output logic [31:0]         ext_rdata
);

  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    sel        = 4'b0000;
    lane_wdata = ZERO_WORD;
    ext_rdata  = ZERO_WORD;

    // addr 00 is the most significant byte of the word
    case (addr_lo)
      2'd0:    rbyte = rdata[31:24];
      2'd1:    rbyte = rdata[23:16];
      2'd2:    rbyte = rdata[15:8];
      default: rbyte = rdata[7:0];
    endcase
    rhalf = addr_lo[1] ? rdata[15:0] : rdata[31:16];

    if (op_is_byte(op)) begin
      sel        = 4'b1000 >> addr_lo;
      lane_wdata = {4{wdata[7:0]}};
    end else if (op_is_half(op)) begin
      sel        = addr_lo[1] ? 4'b0011 : 4'b1100;
      lane_wdata = {2{wdata[15:0]}};
    end else if (op_is_word(op)) begin
      sel        = 4'b1111;
      lane_wdata = wdata;
    end

    case (op)
      MEM_OP_LB:  ext_rdata = {{24{rbyte[7]}}, rbyte};
      MEM_OP_LBU: ext_rdata = {24'h000000, rbyte};
      MEM_OP_LH:  ext_rdata = {{16{rhalf[15]}}, rhalf};
      MEM_OP_LHU: ext_rdata = {16'h0000, rhalf};
      MEM_OP_LW:  ext_rdata = rdata;
      default:    ext_rdata = ZERO_WORD;
    endcase
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - single-outstanding load/store initiator for the byte-lane data RAM
// Ports: clk, rst (async, active-low); request handshake req_valid/req_ready
// with req_op/req_addr/req_wdata; one-cycle resp_valid with resp_rdata;
// stall_o holds the pipeline; mem_ce/mem_we/mem_addr/mem_sel/mem_wdata drive
// the RAM and mem_rdata returns combinationally. WAIT_STATES adds RAM cycles.
// Optional MEM_ALIGN_EXC_EN adds exc_adel/exc_ades/bad_vaddr and turns
// misaligned halfword/word accesses into exceptions instead of truncation.
module mem_access_ctrl
  import mem_access_ctrl_pkg::*;
#(
  parameter int WAIT_STATES = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [MEM_OP_W-1:0] req_op,
  input  logic [31:0]         req_addr,
  input  logic [31:0]         req_wdata,
  output logic                resp_valid,
  output logic [31:0]         resp_rdata,
  output logic                stall_o,
  output logic                mem_ce,
  output logic                mem_we,
  output logic [31:0]         mem_addr,
  output logic [3:0]          mem_sel,
  output logic [31:0]         mem_wdata,
`ifdef MEM_ALIGN_EXC_EN
  output logic                exc_adel,
  output logic                exc_ades,
  output logic [31:0]         bad_vaddr,
`endif
  input  logic [31:0]         mem_rdata
);

  mem_state_e          state_q, state_d;
  logic [3:0]          wait_q;
  logic [MEM_OP_W-1:0] op_q;
  logic [31:0]         addr_q;
  logic [31:0]         wdata_q;
  logic [31:0]         rdata_q;

  logic        accept, in_access, last_access, req_mis, direct_resp;
  logic [3:0]  lane_sel;
  logic [31:0] lane_wdata, ext_rdata;

`ifdef MEM_ALIGN_EXC_EN
  assign req_mis = op_misaligned(req_op, req_addr[1:0]);
`else
  assign req_mis = 1'b0;
`endif

  assign accept      = (state_q == ST_IDLE) && req_valid;
  assign in_access   = (state_q == ST_ACCESS);
  assign last_access = in_access && (wait_q == 4'(WAIT_STATES));
  // NONE, undefined codes and faulting accesses answer without touching the RAM
  assign direct_resp = !(op_is_load(req_op) || op_is_store(req_op)) || req_mis;

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (req_valid) state_d = direct_resp ? ST_RESP : ST_ACCESS;
      ST_ACCESS: if (last_access) state_d = ST_RESP;
      ST_RESP:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
      wait_q  <= 4'd0;
      op_q    <= MEM_OP_NONE;
      addr_q  <= ZERO_WORD;
      wdata_q <= ZERO_WORD;
      rdata_q <= ZERO_WORD;
    end else begin
      state_q <= state_d;
      if (accept) begin
        op_q    <= req_op;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
        wait_q  <= 4'd0;
        if (direct_resp) rdata_q <= ZERO_WORD;
      end else if (in_access) begin
        // result register only moves as RESP is entered, so it holds between responses
        if (last_access) rdata_q <= op_is_load(op_q) ? ext_rdata : ZERO_WORD;
        else             wait_q  <= wait_q + 4'd1;
      end
    end
  end

  mem_lane_align u_lane_align (
    .op         (op_q),
    .addr_lo    (addr_q[1:0]),
    .wdata      (wdata_q),
    .rdata      (mem_rdata),
    .sel        (lane_sel),
    .lane_wdata (lane_wdata),
    .ext_rdata  (ext_rdata)
  );

  assign req_ready  = (state_q == ST_IDLE);
  // gated so a request waiting during reset does not raise the stall
  assign stall_o    = rst && (accept || in_access);
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign mem_ce     = in_access ? CHIP_ENABLE : CHIP_DISABLE;
  assign mem_we     = (in_access && op_is_store(op_q)) ? WRITE_ENABLE : WRITE_DISABLE;
  assign mem_addr   = in_access ? {addr_q[31:2], 2'b00} : ZERO_WORD;
  assign mem_sel    = in_access ? lane_sel : 4'b0000;
  assign mem_wdata  = (in_access && op_is_store(op_q)) ? lane_wdata : ZERO_WORD;

`ifdef MEM_ALIGN_EXC_EN
  logic        exc_load_q, exc_store_q;
  logic [31:0] bad_vaddr_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      exc_load_q  <= 1'b0;
      exc_store_q <= 1'b0;
      bad_vaddr_q <= ZERO_WORD;
    end else if (accept) begin
      exc_load_q  <= req_mis && op_is_load(req_op);
      exc_store_q <= req_mis && op_is_store(req_op);
      if (direct_resp) bad_vaddr_q <= req_mis ? req_addr : ZERO_WORD;
    end else if (last_access) begin
      bad_vaddr_q <= ZERO_WORD;
    end
  end

  assign exc_adel  = resp_valid && exc_load_q;
  assign exc_ades  = resp_valid && exc_store_q;
  assign bad_vaddr = bad_vaddr_q;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - self-checking bench for mem_access_ctrl (WAIT_STATES 0 and 3)
module tb_mem_access_ctrl;

  localparam logic [3:0] OP_NONE = 4'd0, OP_LB = 4'd1, OP_LBU = 4'd2, OP_LH = 4'd3,
                         OP_LHU = 4'd4, OP_LW = 4'd5, OP_SB = 4'd6, OP_SH = 4'd7, OP_SW = 4'd8;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic        req_valid [2];
  logic        req_ready [2];
  logic [3:0]  req_op    [2];
  logic [31:0] req_addr  [2];
  logic [31:0] req_wdata [2];
  logic        resp_valid[2];
  logic [31:0] resp_rdata[2];
  logic        stall_o   [2];
  logic        mem_ce    [2];
  logic        mem_we    [2];
  logic [31:0] mem_addr  [2];
  logic [3:0]  mem_sel   [2];
  logic [31:0] mem_wdata [2];
  logic [31:0] mem_rdata [2];
`ifdef MEM_ALIGN_EXC_EN
  logic        exc_adel  [2];
  logic        exc_ades  [2];
  logic [31:0] bad_vaddr [2];
`endif

  logic [31:0] ram  [2][64];
  logic [31:0] refm [2][64];
  logic        ovr_en[2];
  logic [31:0] ovr   [2];

  int ncmp = 0;
  int nfail = 0;

  assign mem_rdata[0] = ovr_en[0] ? ovr[0] : ram[0][mem_addr[0][7:2]];
  assign mem_rdata[1] = ovr_en[1] ? ovr[1] : ram[1][mem_addr[1][7:2]];

  mem_access_ctrl #(.WAIT_STATES(0)) u_ws0 (
    .clk(clk), .rst(rst_n), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
    .req_op(req_op[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
    .resp_valid(resp_valid[0]), .resp_rdata(resp_rdata[0]), .stall_o(stall_o[0]),
    .mem_ce(mem_ce[0]), .mem_we(mem_we[0]), .mem_addr(mem_addr[0]), .mem_sel(mem_sel[0]),
    .mem_wdata(mem_wdata[0]),
`ifdef MEM_ALIGN_EXC_EN
    .exc_adel(exc_adel[0]), .exc_ades(exc_ades[0]), .bad_vaddr(bad_vaddr[0]),
`endif
    .mem_rdata(mem_rdata[0])
  );

  mem_access_ctrl #(.WAIT_STATES(3)) u_ws3 (
    .clk(clk), .rst(rst_n), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
    .req_op(req_op[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
    .resp_valid(resp_valid[1]), .resp_rdata(resp_rdata[1]), .stall_o(stall_o[1]),
    .mem_ce(mem_ce[1]), .mem_we(mem_we[1]), .mem_addr(mem_addr[1]), .mem_sel(mem_sel[1]),
    .mem_wdata(mem_wdata[1]),
`ifdef MEM_ALIGN_EXC_EN
    .exc_adel(exc_adel[1]), .exc_ades(exc_ades[1]), .bad_vaddr(bad_vaddr[1]),
`endif
    .mem_rdata(mem_rdata[1])
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit misaligned(input logic [3:0] op, input logic [31:0] a);
`ifdef MEM_ALIGN_EXC_EN
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return (a % 2) != 0;
    if (op == OP_LW || op == OP_SW) return (a % 4) != 0;
    return 1'b0;
`else
    return 1'b0;
`endif
  endfunction

  // byte k of a word (k = addr % 4) sits (3-k)*8 bits up from the LSB
  function automatic logic [31:0] model_rd(input logic [3:0] op, input logic [31:0] a, input logic [31:0] w);
    logic [31:0] v;
    int unsigned sh;
    v = 32'h0;
    if (op == OP_LB || op == OP_LBU) begin
      sh = (3 - (a % 4)) * 8;
      v  = (w >> sh) & 32'hFF;
      if (op == OP_LB && v >= 128) v = v - 256;
    end else if (op == OP_LH || op == OP_LHU) begin
      sh = ((a % 4) >= 2) ? 0 : 16;
      v  = (w >> sh) & 32'hFFFF;
      if (op == OP_LH && v >= 32768) v = v - 65536;
    end else if (op == OP_LW) begin
      v = w;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_sel(input logic [3:0] op, input logic [31:0] a);
    if (op == OP_LB || op == OP_LBU || op == OP_SB) return 4'(1 << (3 - (a % 4)));
    if (op == OP_LH || op == OP_LHU || op == OP_SH) return ((a % 4) >= 2) ? 4'd3 : 4'd12;
    if (op == OP_LW || op == OP_SW) return 4'd15;
    return 4'd0;
  endfunction

  function automatic logic [31:0] model_wd(input logic [3:0] op, input logic [31:0] wd);
    if (op == OP_SB) return (wd & 32'hFF) * 32'h0101_0101;
    if (op == OP_SH) return (wd & 32'hFFFF) * 32'h0001_0001;
    return wd;
  endfunction

  function automatic logic [31:0] model_merge(input logic [3:0] op, input logic [31:0] a,
                                              input logic [31:0] w, input logic [31:0] wd);
    int unsigned sh;
    logic [31:0] mask;
    if (op == OP_SB) begin
      sh = (3 - (a % 4)) * 8;
      mask = 32'hFF << sh;
      return (w & ~mask) | ((wd & 32'hFF) << sh);
    end
    if (op == OP_SH) begin
      sh = ((a % 4) >= 2) ? 0 : 16;
      mask = 32'hFFFF << sh;
      return (w & ~mask) | ((wd & 32'hFFFF) << sh);
    end
    return wd;
  endfunction

  task automatic xact(input int w, input logic [3:0] op, input logic [31:0] a,
                      input logic [31:0] wd, input bit glitch, output logic [31:0] rd);
    int ws, exp_lat, k, nce, nrdy;
    bit is_ld, is_st, mis, acc, got;
    logic [31:0] exp_rd;
    logic [5:0] idx, widx;
    ws     = (w == 0) ? 0 : 3;
    is_ld  = (op >= OP_LB) && (op <= OP_LW);
    is_st  = (op >= OP_SB) && (op <= OP_SW);
    mis    = misaligned(op, a);
    acc    = (is_ld || is_st) && !mis;
    exp_lat = acc ? ws + 2 : 1;
    idx    = a[7:2];
    exp_rd = (acc && is_ld) ? model_rd(op, a, refm[w][idx]) : 32'h0;
    rd = 32'h0; got = 1'b0; nce = 0; nrdy = 0; k = 0;

    @(negedge clk);
    req_valid[w] = 1'b1; req_op[w] = op; req_addr[w] = a; req_wdata[w] = wd;
    #1;
    chk("accept_ready", 32'(req_ready[w]), 32'd1);
    chk("accept_stall", 32'(stall_o[w]), 32'd1);
    @(posedge clk);
    #1;
    req_valid[w] = 1'b0; req_op[w] = 4'($urandom); req_addr[w] = $urandom; req_wdata[w] = $urandom;

    while (!got && k < 40) begin
      @(negedge clk);
      k++;
      ovr_en[w] = glitch && (k <= ws);
      ovr[w]    = $urandom;
      #1;
      if (!req_ready[w]) nrdy++;
      if (mem_ce[w]) begin
        nce++;
        if (nce == 1) begin
          chk("mem_addr", mem_addr[w], {a[31:2], 2'b00});
          chk("mem_sel", 32'(mem_sel[w]), 32'(model_sel(op, a)));
          chk("mem_we", 32'(mem_we[w]), 32'(is_st));
          if (is_st) chk("mem_wdata", mem_wdata[w], model_wd(op, wd));
        end
        if (mem_we[w]) begin
          widx = mem_addr[w][7:2];
          for (int b = 0; b < 4; b++)
            if (mem_sel[w][b]) ram[w][widx][8*b +: 8] = mem_wdata[w][8*b +: 8];
        end
      end
      if (resp_valid[w]) begin
        got = 1'b1;
        rd  = resp_rdata[w];
        chk("latency", 32'(k), 32'(exp_lat));
        chk("resp_rdata", resp_rdata[w], exp_rd);
        chk("resp_stall", 32'(stall_o[w]), 32'd0);
`ifdef MEM_ALIGN_EXC_EN
        chk("exc_adel", 32'(exc_adel[w]), 32'(mis && is_ld));
        chk("exc_ades", 32'(exc_ades[w]), 32'(mis && is_st));
        if (mis) chk("bad_vaddr", bad_vaddr[w], a);
`endif
      end
    end
    ovr_en[w] = 1'b0;
    chk("resp_seen", 32'(got), 32'd1);
    chk("ce_cycles", 32'(nce), acc ? 32'(ws + 1) : 32'd0);
    chk("ready_low", 32'(nrdy), 32'(exp_lat));
    @(negedge clk);
    #1;
    chk("ready_back", 32'(req_ready[w]), 32'd1);
    chk("resp_pulse", 32'(resp_valid[w]), 32'd0);
    chk("rdata_hold", resp_rdata[w], exp_rd);
    if (acc && is_st) refm[w][idx] = model_merge(op, a, refm[w][idx], wd);
  endtask

  task automatic chk_idle_outputs(input int w, input string tag);
    chk({tag, "_ready"}, 32'(req_ready[w]), 32'd1);
    chk({tag, "_resp_valid"}, 32'(resp_valid[w]), 32'd0);
    chk({tag, "_resp_rdata"}, resp_rdata[w], 32'd0);
    chk({tag, "_stall"}, 32'(stall_o[w]), 32'd0);
    chk({tag, "_ce"}, 32'(mem_ce[w]), 32'd0);
    chk({tag, "_we"}, 32'(mem_we[w]), 32'd0);
    chk({tag, "_addr"}, mem_addr[w], 32'd0);
    chk({tag, "_sel"}, 32'(mem_sel[w]), 32'd0);
    chk({tag, "_wdata"}, mem_wdata[w], 32'd0);
  endtask

  logic [31:0] rd;
  logic [3:0]  rop;
  logic [31:0] raddr;

  initial begin
    rst_n = 1'b0;
    for (int i = 0; i < 2; i++) begin
      req_valid[i] = 1'b0; req_op[i] = OP_NONE; req_addr[i] = 32'h0; req_wdata[i] = 32'h0;
      ovr_en[i] = 1'b0; ovr[i] = 32'h0;
      for (int j = 0; j < 64; j++) begin
        ram[i][j]  = $urandom;
        refm[i][j] = ram[i][j];
      end
    end
    ram[0][8] = 32'h80F1_7F00; refm[0][8] = 32'h80F1_7F00;
    ram[1][8] = 32'h80F1_7F00; refm[1][8] = 32'h80F1_7F00;

    #2;
    chk_idle_outputs(0, "reset0");
    chk_idle_outputs(1, "reset3");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    xact(0, OP_SW,  32'h10, 32'hDEAD_BEEF, 1'b0, rd); chk("sw_rdata", rd, 32'h0);
    xact(0, OP_LW,  32'h10, 32'h0, 1'b0, rd);         chk("sw_readback", rd, 32'hDEAD_BEEF);
    xact(0, OP_LB,  32'h21, 32'h0, 1'b0, rd);         chk("lb_21", rd, 32'hFFFF_FFF1);
    xact(0, OP_LBU, 32'h21, 32'h0, 1'b0, rd);         chk("lbu_21", rd, 32'h0000_00F1);
    xact(0, OP_LB,  32'h22, 32'h0, 1'b0, rd);         chk("lb_22", rd, 32'h0000_007F);
    xact(0, OP_LH,  32'h20, 32'h0, 1'b0, rd);         chk("lh_20", rd, 32'hFFFF_80F1);
    xact(0, OP_LHU, 32'h22, 32'h0, 1'b0, rd);         chk("lhu_22", rd, 32'h0000_7F00);
    xact(0, OP_SB,  32'h33, 32'h0000_00AB, 1'b0, rd);
    xact(0, OP_SH,  32'h32, 32'h0000_1234, 1'b0, rd);
    xact(0, OP_LW,  32'h30, 32'h0, 1'b0, rd);
    xact(0, OP_NONE, 32'h44, 32'h0, 1'b0, rd);        chk("none_rdata", rd, 32'h0);
    xact(0, 4'd12,  32'h48, 32'h0, 1'b0, rd);
    xact(0, OP_LW,  32'h41, 32'h0, 1'b0, rd);
    xact(0, OP_SH,  32'h43, 32'hCAFE, 1'b0, rd);
    xact(1, OP_LW,  32'h20, 32'h0, 1'b1, rd);         chk("lw_ws3_glitch", rd, 32'h80F1_7F00);
    xact(1, OP_LH,  32'h22, 32'h0, 1'b1, rd);

    for (int n = 0; n < 40; n++) begin
      rop   = 4'($urandom_range(0, 10));
      raddr = 32'($urandom_range(0, 255)) | (($urandom_range(0, 1) == 1) ? 32'h7FFF_0000 : 32'h0);
      xact(n % 2, rop, raddr, $urandom, (n % 4) == 1, rd);
    end

    // reset dropped in the second ACCESS cycle of a WAIT_STATES=3 load
    @(negedge clk);
    req_valid[1] = 1'b1; req_op[1] = OP_LW; req_addr[1] = 32'h24;
    @(posedge clk);
    #1;
    req_valid[1] = 1'b0;
    @(posedge clk);
    #2;
    chk("rst_pre_ce", 32'(mem_ce[1]), 32'd1);
    rst_n = 1'b0;
    #1;
    chk_idle_outputs(1, "rst_async");
    repeat (3) begin
      @(negedge clk);
      chk("rst_hold_resp", 32'(resp_valid[1]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      #1;
      chk("rst_no_resp", 32'(resp_valid[1]), 32'd0);
      chk("rst_no_ce", 32'(mem_ce[1]), 32'd0);
      chk("rst_ready", 32'(req_ready[1]), 32'd1);
    end
    xact(1, OP_LBU, 32'h23, 32'h0, 1'b0, rd);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule
